// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt controller:
//   irq_state_t      - request/service FSM state encoding (IDLE, REQ, SERVICE)
//   NUM_SRC_DEFAULT  - default number of interrupt source lines
// ---------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int NUM_SRC_DEFAULT = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: reports the lowest set bit of the input vector,
// so index 0 has the highest priority.
// Ports:
//   i_vec    [NUM_SRC-1:0]  candidate request vector
//   o_index  [ID_W-1:0]     index of the lowest set bit (0 when none set)
//   o_valid                 at least one bit of i_vec is set
// ---------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_vec,
    output logic [ID_W-1:0]    o_index,
    output logic               o_valid
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        o_index = '0;
        o_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = ID_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
// Edge-triggered interrupt controller with an enable mask, per-source pending
// bits and a three-state request/claim/complete handshake to the core.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   src        [NUM_SRC-1:0] peripheral level inputs; a rising edge requests
//   en_we      enable-mask write strobe
//   en_wdata   [NUM_SRC-1:0] enable-mask write data
//   en_mask    [NUM_SRC-1:0] current enable mask
//   pending    [NUM_SRC-1:0] current pending bits
//   interrupt  registered request to the core / halt unit (1 only in REQ)
//   irq_id     [ID_W-1:0] index of the source requested or being serviced
//   irq_ack    core claims the current request (honoured only in REQ)
//   irq_done   core finished the handler (honoured only in SERVICE)
//
// Build option:
//   IRQ_SYNC_EN  when defined, each source passes through a two-flop
//                synchronizer ahead of the sampling flop (+2 cycles latency).
// ---------------------------------------------------------------------------
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    output logic [NUM_SRC-1:0] en_mask,
    output logic [NUM_SRC-1:0] pending,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_done
);

    logic [NUM_SRC-1:0] r_samp;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_en_mask;
    irq_state_t         r_state;
    logic               r_interrupt;
    logic [ID_W-1:0]    r_irq_id;

    logic [NUM_SRC-1:0] w_src_in;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_clr;
    logic [ID_W-1:0]    w_idx;
    logic               w_valid;
    logic               w_ack_req;
    logic               w_withdraw;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_in = r_sync2;
`else
    assign w_src_in = src;
`endif

    // Sampling flop plus history flop. History clears on reset, so a source
    // held high through reset reads as a fresh edge once released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp <= '0;
            r_prev <= '0;
        end else begin
            r_samp <= w_src_in;
            r_prev <= r_samp;
        end
    end

    assign w_edge   = r_samp & ~r_prev;
    assign w_active = r_pending & r_en_mask;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .i_vec   (w_active),
        .o_index (w_idx),
        .o_valid (w_valid)
    );

    // A claim takes effect only while a request is being presented. If the
    // core claims on the same edge the mask drops, the claim still wins:
    // interrupt was high when the core decided to take it.
    assign w_ack_req  = (r_state == REQ) && irq_ack;
    assign w_withdraw = (r_state == REQ) && !irq_ack && !r_en_mask[r_irq_id];

    always_comb begin
        w_clr = '0;
        if (w_ack_req) begin
            w_clr[r_irq_id] = 1'b1;
        end
    end

    // Clear is applied before set so a new edge on the claimed source
    // survives the claim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_mask <= '0;
        end else if (en_we) begin
            r_en_mask <= en_wdata;
        end
    end

    // Request FSM; interrupt is registered alongside the state so it is
    // high for exactly the REQ cycles and never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_interrupt <= 1'b0;
            r_irq_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state     <= REQ;
                        r_interrupt <= 1'b1;
                        r_irq_id    <= w_idx;
                    end
                end
                REQ: begin
                    if (w_ack_req) begin
                        r_state     <= SERVICE;
                        r_interrupt <= 1'b0;
                    end else if (w_withdraw) begin
                        r_state     <= IDLE;
                        r_interrupt <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        r_state <= IDLE;
                    end
                    r_interrupt <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_interrupt <= 1'b0;
                end
            endcase
        end
    end

    assign en_mask   = r_en_mask;
    assign pending   = r_pending;
    assign interrupt = r_interrupt;
    assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
// Scoreboard bench for irq_ctrl (NUM_SRC = 8). The stimulus process drives
// inputs on the falling edge, advances a behavioural model for the coming
// rising edge and queues the expected outputs. The monitor process pops one
// entry for every rising clock edge and every reset assertion and compares.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] src;
    logic       en_we;
    logic [7:0] en_wdata;
    logic [7:0] en_mask;
    logic [7:0] pending;
    logic       interrupt;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       irq_done;

    irq_ctrl #(
        .NUM_SRC (8),
        .ID_W    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .en_we     (en_we),
        .en_wdata  (en_wdata),
        .en_mask   (en_mask),
        .pending   (pending),
        .interrupt (interrupt),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] mask;
        logic       intr;
        logic [2:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model. m_mode: 0 idle, 1 requesting, 2 being serviced.
    // m_hist[k] is the src value applied k+1 rising edges ago (zeroed by
    // reset); an edge is seen D edges after it was applied.
    int       m_mode;
    bit [7:0] m_pend;
    bit [7:0] m_mask;
    bit [2:0] m_id;
    bit [7:0] m_hist [0:4];
    bit [7:0] cur;

    function automatic exp_t model_view();
        exp_t e;
        e.pend = m_pend;
        e.mask = m_mask;
        e.intr = (m_mode == 1);
        e.id   = m_id;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pend = 8'h00;
        m_mask = 8'h00;
        m_id   = 3'd0;
        for (int k = 0; k < 5; k++) m_hist[k] = 8'h00;
    endtask

    task automatic model_clock(input bit [7:0] s, input bit we, input bit [7:0] wd,
                               input bit ack, input bit done);
        bit [7:0] rise;
        bit [7:0] act;
        bit [7:0] clr;
        bit       found;
        rise  = m_hist[D-1] & ~m_hist[D];
        act   = m_pend & m_mask;
        clr   = 8'h00;
        found = 1'b0;
        if (m_mode == 0) begin
            for (int i = 0; i < 8; i++) begin
                if (act[i] && !found) begin
                    found  = 1'b1;
                    m_id   = 3'(i);
                    m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                clr[m_id] = 1'b1;
                m_mode    = 2;
            end else if (!m_mask[m_id]) begin
                m_mode = 0;
            end
        end else begin
            if (done) m_mode = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (we) m_mask = wd;
        for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
    endtask

    task automatic cyc(input bit [7:0] s, input bit we, input bit [7:0] wd,
                       input bit ack, input bit done);
        @(negedge clk);
        reset    = 1'b0;
        src      = s;
        en_we    = we;
        en_wdata = wd;
        irq_ack  = ack;
        irq_done = done;
        model_clock(s, we, wd, ack, done);
        exp_q.push_back(model_view());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(cur, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is raised mid-cycle, checked before any clock, then held across
    // one rising edge; the next cyc() releases it.
    task automatic do_reset();
        @(negedge clk);
        #2;
        model_reset();
        exp_q.push_back(model_view());
        reset = 1'b1;
        exp_q.push_back(model_view());
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20; k++) begin
            if (m_mode == 1) break;
            cyc(cur, 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic serve();
        wait_req();
        cyc(cur, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        cyc(cur, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        exp_t got;
        #1;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            got.pend = pending;
            got.mask = en_mask;
            got.intr = interrupt;
            got.id   = irq_id;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t: got pend=%h mask=%h int=%b id=%0d",
                         $time, got.pend, got.mask, got.intr, got.id);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs at %0t: got pend=%h mask=%h int=%b id=%0d, expected pend=%h mask=%h int=%b id=%0d",
                             $time, got.pend, got.mask, got.intr, got.id,
                             e.pend, e.mask, e.intr, e.id);
                end
            end
        end
    end

    // Stimulus
    initial begin
        src      = 8'h00;
        en_we    = 1'b0;
        en_wdata = 8'h00;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        reset    = 1'b0;
        cur      = 8'h00;
        model_reset();

        do_reset();

        // Reset release, enable everything, nothing pending
        cyc(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        idle(3);

        // Basic latency on source 3
        cur = 8'h08;
        idle(6);
        serve();
        cur = 8'h00;
        idle(3);

        // Priority: sources 5 and 2 together
        cur = 8'h24;
        idle(1);
        serve();
        serve();
        cur = 8'h00;
        idle(3);

        // Masked pending, then enable source 1
        cyc(cur, 1'b1, 8'h00, 1'b0, 1'b0);
        cur = 8'h02;
        idle(6);
        cyc(cur, 1'b1, 8'h02, 1'b0, 1'b0);
        idle(2);
        serve();
        cur = 8'h00;
        idle(2);

        // Set-wins collision on source 4
        cyc(cur, 1'b1, 8'hFF, 1'b0, 1'b0);
        cur = 8'h10;
        idle(1);
        cur = 8'h00;
        wait_req();
        cur = 8'h10;
        idle(D);
        cyc(cur, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(cur, 1'b0, 8'h00, 1'b0, 1'b1);
        serve();
        cur = 8'h00;
        idle(2);

        // Withdraw on source 6, then reset while in service
        cur = 8'h40;
        idle(1);
        cur = 8'h00;
        wait_req();
        cyc(cur, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(3);
        cyc(cur, 1'b1, 8'hFF, 1'b0, 1'b0);
        wait_req();
        cyc(cur, 1'b0, 8'h00, 1'b1, 1'b0);
        do_reset();
        idle(3);

        // Source held high through reset yields one edge after release
        cur = 8'h01;
        idle(1);
        do_reset();
        cyc(cur, 1'b1, 8'hFF, 1'b0, 1'b0);
        idle(4);
        serve();
        cur = 8'h00;
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit [7:0] wd;
            cur = cur ^ 8'($urandom & $urandom & $urandom);
            wd  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            cyc(cur, ($urandom_range(0, 7) == 0), wd,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        idle(2);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
